// File: rtl/jk_pkg.sv
// Shared definitions for the JK drive sequencer: drive codes, FSM state and command layout.
package jk_pkg;

   localparam int JK_CNT_W = 8;

   localparam logic [1:0] JK_HOLD   = 2'b00;
   localparam logic [1:0] JK_RESET  = 2'b01;
   localparam logic [1:0] JK_SET    = 2'b10;
   localparam logic [1:0] JK_TOGGLE = 2'b11;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_DRIVE = 1'b1
   } jk_state_t;

   typedef struct packed {
      logic [1:0]          op;
      logic [JK_CNT_W-1:0] len;
   } jk_cmd_t;

endpackage

// File: rtl/jk_cmd_fifo.sv
// Command FIFO for the JK drive sequencer; DEPTH must be a power of 2.
// A push into an empty FIFO becomes visible at the head on the following edge.
module jk_cmd_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 10
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] wdata,
   input  logic         pop,
   output logic [W-1:0] rdata,
   output logic         full,
   output logic         empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0]  mem_r [DEPTH];
   logic [AW-1:0] wr_ptr_r;
   logic [AW-1:0] rd_ptr_r;
   logic [AW:0]   cnt_r;
   logic          do_push_s;
   logic          do_pop_s;

   assign full      = (cnt_r == (AW+1)'(DEPTH));
   assign empty     = (cnt_r == {(AW+1){1'b0}});
   assign do_push_s = push & ~full;
   assign do_pop_s  = pop & ~empty;
   assign rdata     = mem_r[rd_ptr_r];

   // pointer and occupancy bookkeeping
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         cnt_r    <= {(AW+1){1'b0}};
      end else begin
         if (do_push_s) begin
            wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
         end
         if (do_pop_s) begin
            rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
         end
         case ({do_push_s, do_pop_s})
            2'b10:   cnt_r <= cnt_r + {{AW{1'b0}}, 1'b1};
            2'b01:   cnt_r <= cnt_r - {{AW{1'b0}}, 1'b1};
            default: cnt_r <= cnt_r;
         endcase
      end
   end

   // storage array write port
   always_ff @(posedge clk) begin
      if (do_push_s) begin
         mem_r[wr_ptr_r] <= wdata;
      end
   end

endmodule

// File: rtl/jk_drive_sequencer.sv
// Queued J/K drive sequencer feeding a JK flip-flop.
// Define JK_SEQ_CHECK_EN to build the exp_q reference model and the sticky mismatch flag.
module jk_drive_sequencer
   import jk_pkg::*;
#(
   parameter int CNT_W = JK_CNT_W,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [CNT_W-1:0] cmd_len,
   output logic             J,
   output logic             K,
   input  logic             q_in,
   output logic             busy,
   output logic             done,
   output logic             exp_q,
   output logic             mismatch
);

   localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   jk_state_t          state_r, state_s;
   logic [CNT_W-1:0]   rem_r, rem_s;
   logic [1:0]         jk_r, jk_s;
   logic               done_r, done_s;
   logic               pop_s;
   logic               full_s, empty_s;
   logic [CNT_W+1:0]   head_s;
   logic [1:0]         head_op_s;
   logic [CNT_W-1:0]   head_rem_s;

   jk_cmd_fifo #(
      .DEPTH (DEPTH),
      .W     (CNT_W + 2)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (cmd_valid),
      .wdata ({cmd_op, cmd_len}),
      .pop   (pop_s),
      .rdata (head_s),
      .full  (full_s),
      .empty (empty_s)
   );

   // a zero length still drives the op for one cycle
   assign head_op_s  = head_s[CNT_W+1:CNT_W];
   assign head_rem_s = (head_s[CNT_W-1:0] == {CNT_W{1'b0}}) ? ONE : head_s[CNT_W-1:0];

   assign cmd_ready = ~full_s;
   assign busy      = (state_r == ST_DRIVE) | ~empty_s;
   assign J         = jk_r[1];
   assign K         = jk_r[0];
   assign done      = done_r;

   // next-state, repeat counter and drive code selection
   always_comb begin
      state_s = state_r;
      rem_s   = rem_r;
      jk_s    = jk_r;
      done_s  = 1'b0;
      pop_s   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (!empty_s) begin
               pop_s   = 1'b1;
               jk_s    = head_op_s;
               rem_s   = head_rem_s;
               state_s = ST_DRIVE;
            end else begin
               jk_s = JK_HOLD;
            end
         end
         ST_DRIVE: begin
            if (rem_r == ONE) begin
               if (!empty_s) begin
                  pop_s = 1'b1;
                  jk_s  = head_op_s;
                  rem_s = head_rem_s;
               end else begin
                  jk_s    = JK_HOLD;
                  done_s  = 1'b1;
                  state_s = ST_IDLE;
               end
            end else begin
               rem_s = rem_r - ONE;
            end
         end
         default: begin
            jk_s    = JK_HOLD;
            state_s = ST_IDLE;
         end
      endcase
   end

   // sequencer state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_IDLE;
         rem_r   <= {CNT_W{1'b0}};
         jk_r    <= JK_HOLD;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         rem_r   <= rem_s;
         jk_r    <= jk_s;
         done_r  <= done_s;
      end
   end

`ifdef JK_SEQ_CHECK_EN
   logic exp_q_r;
   logic mismatch_r;

   // reference flip-flop and sticky divergence flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         exp_q_r    <= 1'b0;
         mismatch_r <= 1'b0;
      end else begin
         case (jk_r)
            JK_HOLD:   exp_q_r <= exp_q_r;
            JK_RESET:  exp_q_r <= 1'b0;
            JK_SET:    exp_q_r <= 1'b1;
            JK_TOGGLE: exp_q_r <= ~exp_q_r;
            default:   exp_q_r <= exp_q_r;
         endcase
         if (q_in != exp_q_r) begin
            mismatch_r <= 1'b1;
         end else begin
            mismatch_r <= mismatch_r;
         end
      end
   end

   assign exp_q    = exp_q_r;
   assign mismatch = mismatch_r;
`else
   logic unused_q_in_s;

   assign unused_q_in_s = q_in;
   assign exp_q         = 1'b0;
   assign mismatch      = 1'b0;
`endif

endmodule

// File: tb/tb_jk_drive_sequencer.sv
// Scoreboard bench for jk_drive_sequencer: accepted commands are expanded into a per-cycle
// expected J/K schedule; a behavioural JK flip-flop closes the q_in loop.
module tb_jk_drive_sequencer;
   import jk_pkg::*;

   localparam int CNT_W = 8;
   localparam int DEPTH = 4;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             cmd_valid = 1'b0;
   logic             cmd_ready;
   logic [1:0]       cmd_op = 2'b00;
   logic [CNT_W-1:0] cmd_len = 8'd0;
   logic             J, K, q_in, busy, done, exp_q, mismatch;
   logic             q_ff;
   logic             flip = 1'b0;

   typedef struct {
      int         cyc;
      logic [1:0] op;
   } sb_t;

   sb_t  sb_q[$];
   int   cyc = 0;
   int   last_end = -10;
   logic mism_exp = 1'b0;
   bit   prev_drive = 1'b0;
   int   n_checks = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   jk_drive_sequencer #(.CNT_W(CNT_W), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_len   (cmd_len),
      .J         (J),
      .K         (K),
      .q_in      (q_in),
      .busy      (busy),
      .done      (done),
      .exp_q     (exp_q),
      .mismatch  (mismatch)
   );

   // behavioural flip-flop downstream of the sequencer
   always @(posedge clk or posedge rst) begin
      if (rst) q_ff <= 1'b0;
      else begin
         case ({J, K})
            2'b01:   q_ff <= 1'b0;
            2'b10:   q_ff <= 1'b1;
            2'b11:   q_ff <= ~q_ff;
            default: q_ff <= q_ff;
         endcase
      end
   end

   assign q_in = q_ff ^ flip;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // expected schedule: a command starts after its accept edge and after the previous one ends
   always @(posedge clk) begin : sb_push
      int n, st;
      cyc = cyc + 1;
      if (rst) begin
         sb_q.delete();
         last_end = -10;
         mism_exp = 1'b0;
      end else begin
         if (cmd_valid && cmd_ready) begin
            n  = (cmd_len == 8'd0) ? 1 : int'(cmd_len);
            st = (cyc + 1 > last_end + 1) ? cyc + 1 : last_end + 1;
            for (int i = 0; i < n; i++) sb_q.push_back('{cyc: st + i, op: cmd_op});
            last_end = st + n - 1;
         end
`ifdef JK_SEQ_CHECK_EN
         if (q_in !== q_ff) mism_exp = 1'b1;
`endif
      end
   end

   // per-cycle comparison against the schedule
   always @(negedge clk) begin : sb_check
      logic [1:0] e_jk;
      bit         cur;
      logic       e_q;
      if (rst) begin
         prev_drive = 1'b0;
      end else begin
         cur  = 1'b0;
         e_jk = 2'b00;
         if (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
            e_jk = sb_q[0].op;
            cur  = 1'b1;
            void'(sb_q.pop_front());
         end
`ifdef JK_SEQ_CHECK_EN
         e_q = q_ff;
`else
         e_q = 1'b0;
`endif
         check_eq("jk", {30'd0, J, K}, {30'd0, e_jk});
         check_eq("done", {31'd0, done}, {31'd0, prev_drive && !cur});
         check_eq("busy", {31'd0, busy}, {31'd0, cur || (sb_q.size() > 0)});
         check_eq("exp_q", {31'd0, exp_q}, {31'd0, e_q});
         check_eq("mismatch", {31'd0, mismatch}, {31'd0, mism_exp});
         prev_drive = cur;
      end
   end

   task automatic send(input logic [1:0] op, input logic [CNT_W-1:0] len);
      int k;
      jk_cmd_t c;
      c.op  = op;
      c.len = len;
      cmd_valid = 1'b1;
      cmd_op    = c.op;
      cmd_len   = c.len;
      k = 0;
      while (!cmd_ready && k < 300) begin
         @(negedge clk);
         k++;
      end
      if (k >= 300) check_eq("send_timeout", 32'd1, 32'd0);
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int k;
      k = 0;
      while ((busy || J || K || sb_q.size() > 0) && k < 300) begin
         @(negedge clk);
         k++;
      end
      if (k >= 300) check_eq("idle_timeout", 32'd1, 32'd0);
      repeat (3) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check_eq("rst_jk", {30'd0, J, K}, 32'd0);
      check_eq("rst_ready", {31'd0, cmd_ready}, 32'd1);
      check_eq("rst_busy", {31'd0, busy}, 32'd0);
      check_eq("rst_done", {31'd0, done}, 32'd0);
      check_eq("rst_exp_q", {31'd0, exp_q}, 32'd0);
      check_eq("rst_mismatch", {31'd0, mismatch}, 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      #1 rst = 1'b1;
      #1;
      check_eq("por_jk", {30'd0, J, K}, 32'd0);
      check_eq("por_ready", {31'd0, cmd_ready}, 32'd1);
      check_eq("por_busy", {31'd0, busy}, 32'd0);
      check_eq("por_exp_q", {31'd0, exp_q}, 32'd0);
      check_eq("por_mismatch", {31'd0, mismatch}, 32'd0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      send(JK_SET, 8'd3);
      wait_idle();

      do_reset();
      send(JK_TOGGLE, 8'd2);
      send(JK_SET, 8'd0);
      wait_idle();

      send(JK_SET, 8'd10);
      send(JK_TOGGLE, 8'd10);
      send(JK_RESET, 8'd10);
      send(JK_HOLD, 8'd10);
      send(JK_TOGGLE, 8'd10);
      check_eq("full_ready", {31'd0, cmd_ready}, 32'd0);
      send(JK_SET, 8'd10);
      wait_idle();

      send(JK_TOGGLE, 8'd5);
      send(JK_SET, 8'd1);
      send(JK_RESET, 8'd1);
      do_reset();
      repeat (20) @(negedge clk);
      check_eq("post_rst_busy", {31'd0, busy}, 32'd0);

      send(JK_SET, 8'd4);
      repeat (2) @(negedge clk);
      flip = 1'b1;
      @(negedge clk);
      flip = 1'b0;
      wait_idle();
      repeat (5) @(negedge clk);
`ifdef JK_SEQ_CHECK_EN
      check_eq("mism_sticky", {31'd0, mismatch}, 32'd1);
`else
      check_eq("mism_tied", {31'd0, mismatch}, 32'd0);
`endif
      do_reset();
      repeat (3) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/jk_drive_sequencer.md
# jk_drive_sequencer

Command-driven stimulus stage that sits directly upstream of the JK flip-flop. It accepts queued drive commands (hold/reset/set/toggle plus a repeat length) over a valid/ready handshake and drives the flip-flop's J and K inputs for the requested number of cycles. An optional reference model tracks the expected Q and flags any divergence from the Q fed back by the flip-flop.

## Interface
- CNT_W, 8: width of the repeat-length field.
- DEPTH, 4: command FIFO depth; must be a power of 2, at least 2.
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  FIFO can accept; equals FIFO not full
- cmd_op  in  2  drive code, applied as {J,K}: 00 hold, 01 reset, 10 set, 11 toggle
- cmd_len  in  CNT_W  number of drive cycles; 0 is treated as 1
- J  out  1  registered J to the flip-flop
- K  out  1  registered K to the flip-flop
- q_in  in  1  Q fed back from the flip-flop
- busy  out  1  state DRIVE or FIFO non-empty
- done  out  1  one-cycle pulse when the sequencer returns to idle
- exp_q  out  1  model Q (see Configuration)
- mismatch  out  1  sticky model/DUT divergence (see Configuration)

## Operation
- Handshake: a command is written to the FIFO on a clock edge where cmd_valid and cmd_ready are both 1. The op and len fields must be stable while cmd_valid is high.
- FSM has two states.
  - IDLE: J=K=0. If the FIFO is non-empty, pop the head, load the op into {J,K}, set remaining = max(len,1), and go to DRIVE.
  - DRIVE: decrement remaining on each edge.
    - When remaining==1 and the FIFO is non-empty, pop the next command on the same edge. There is no bubble, and done is not pulsed.
    - When remaining==1 and the FIFO is empty, set J=K=0, pulse done, and go to IDLE.
- A push and a pop on the same edge are legal. A push into an empty FIFO is not visible to a pop until the following edge.
- When the FIFO is full, cmd_ready is 0 and any offered command is held by the upstream, not dropped.
- Reset values: J=K=0, FIFO empty, cmd_ready=1, busy=0, done=0, exp_q=0, mismatch=0, state IDLE.
- Reset mid-operation: the in-flight command and all queued commands are discarded, and no done pulse is produced. The flip-flop shares rst, so Q and exp_q both return to 0.

## Timing
- Cycle n is the interval after edge n.
- A command accepted at edge 0 into an idle, empty block drives its op on J/K in cycles 1..N.
  - J=K=0 and done=1 in cycle N+1.
  - The flip-flop first updates Q at edge 2.
- Back-to-back commands produce contiguous op cycles.
- exp_q is updated on each edge from the current {J,K} using flip-flop semantics, so in every cycle it matches the correct Q exactly.
- mismatch is set at the edge following any cycle where q_in != exp_q, and stays set until rst.

## Configuration
- JK_SEQ_CHECK_EN defined: the exp_q model and the mismatch comparator are built.
- JK_SEQ_CHECK_EN undefined: exp_q and mismatch are tied to 0, q_in is ignored, and all other behaviour is identical.

## Structure
- Package jk_pkg holds the following.
  - Op constants: JK_HOLD=2'b00, JK_RESET=2'b01, JK_SET=2'b10, JK_TOGGLE=2'b11.
  - The sequencer state enum (ST_IDLE, ST_DRIVE).
  - The command struct {op, len}.
- One sub-module, jk_cmd_fifo: a synchronous FIFO with parameters DEPTH and width 2+CNT_W, ports push/pop/full/empty, and reset to empty.
- The FSM, counter, and checker live in the top module.

## Test plan
- Reset: assert rst mid-cycle → J=K=0, cmd_ready=1, busy=0, exp_q=0, mismatch=0 immediately (asynchronous).
- Single SET: SET len 3 accepted at edge 0 → {J,K}=10 in cycles 1–3, done=1 in cycle 4, Q=exp_q=1 from cycle 2.
- Back-to-back with len=0: TOGGLE len 2 then SET len 0 queued → {J,K}=11,11,10 in cycles 1–3, a single done in cycle 4; Q goes 0→1→0→1.
- Full FIFO, DEPTH=4: offer 6 commands of len 10 on consecutive cycles → first popped at edge 1, cmd_ready=0 once 4 are queued, sixth held until a pop frees a slot, all 6 executed in order.
- Reset mid-DRIVE: rst during cycle 2 of a len-5 TOGGLE with 2 commands queued → J=K=0, FIFO empty, no done, busy=0.
- Checker (JK_SEQ_CHECK_EN): force q_in=0 while exp_q=1 for one cycle → mismatch=1 from the next edge and held until rst. Without the macro, mismatch stays 0.
